// File: rtl/reg_space_pkg.sv
// Shared field layout constants and the address decoder for the register array.
package reg_space_pkg;

   localparam int F1_LSB = 0;
   localparam int F2_LSB = 2;
   localparam int F2_W   = 2;
   localparam int F3_LSB = 4;
   localparam int F3_W   = 3;
   localparam int F4_LSB = 8;
   localparam int F4_W   = 4;

   typedef struct packed {
      logic       hit;
      logic [5:0] idx;
   } dec_t;

   // Mapped only on an exact stride boundary and below the register count.
   function automatic dec_t decode(input logic [31:0] addr,
                                   input int          stride_log2,
                                   input int          reg_num);
      dec_t        d;
      logic [31:0] q;
      logic [31:0] mask;
      q     = addr >> stride_log2;
      mask  = (32'd1 << stride_log2) - 32'd1;
      d.hit = ((addr & mask) == 32'd0) && (q < 32'(reg_num));
      d.idx = q[5:0];
      return d;
   endfunction

endpackage

// File: rtl/reg_space_rw_entry.sv
// One register: fields 2-4 with hardware-over-software update priority and packed read-back.
module reg_space_rw_entry
   import reg_space_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_we_i,
   input  logic [DATA_W-1:0] sw_wdata_i,
   input  logic              f2_wvld_i,
   input  logic [F2_W-1:0]   f2_wdat_i,
   input  logic              f3_wvld_i,
   input  logic [F3_W-1:0]   f3_wdat_i,
   input  logic              f4_wvld_i,
   input  logic [F4_W-1:0]   f4_wdat_i,
   output logic [F2_W-1:0]   f2_rdat_o,
   output logic [F3_W-1:0]   f3_rdat_o,
   output logic [F4_W-1:0]   f4_rdat_o,
   output logic [DATA_W-1:0] rword_o
);

   logic [F2_W-1:0] f2_q, f2_d;
   logic [F3_W-1:0] f3_q, f3_d;
   logic [F4_W-1:0] f4_q, f4_d;

   // Each field resolves its own priority, so a HW write to one field leaves the others to SW.
   always_comb begin
      f2_d = f2_q;
      f3_d = f3_q;
      f4_d = f4_q;
      if (f2_wvld_i)    f2_d = f2_wdat_i;
      else if (sw_we_i) f2_d = sw_wdata_i[F2_LSB +: F2_W];
      if (f3_wvld_i)    f3_d = f3_wdat_i;
      else if (sw_we_i) f3_d = sw_wdata_i[F3_LSB +: F3_W];
      if (f4_wvld_i)    f4_d = f4_wdat_i;
      else if (sw_we_i) f4_d = sw_wdata_i[F4_LSB +: F4_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f2_q <= '0;
         f3_q <= '0;
         f4_q <= '0;
      end else begin
         f2_q <= f2_d;
         f3_q <= f3_d;
         f4_q <= f4_d;
      end
   end

   always_comb begin
      rword_o                  = '0;
      rword_o[F2_LSB +: F2_W]  = f2_q;
      rword_o[F3_LSB +: F3_W]  = f3_q;
      rword_o[F4_LSB +: F4_W]  = f4_q;
   end

   assign f2_rdat_o = f2_q;
   assign f3_rdat_o = f3_q;
   assign f4_rdat_o = f4_q;

endmodule

// File: rtl/reg_space_rw_array.sv
// Register array top: address decode, field1 write pulses, one-slot read response buffer, wreq_err.
module reg_space_rw_array
   import reg_space_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int REG_NUM    = 2,
   parameter int REG_STRIDE = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       rreq_addr_i,
   input  logic                    rreq_vld_i,
   output logic                    rreq_rdy_o,
   output logic [DATA_W-1:0]       rack_data_o,
   output logic                    rack_err_o,
   output logic                    rack_vld_o,
   input  logic                    rack_rdy_i,
   input  logic [ADDR_W-1:0]       wreq_addr_i,
   input  logic [DATA_W-1:0]       wreq_data_i,
   input  logic                    wreq_vld_i,
   output logic                    wreq_rdy_o,
   output logic                    wreq_err_o,
   output logic [REG_NUM-1:0]      sw_field1_wdat_o,
   output logic [REG_NUM-1:0]      sw_field1_wvld_o,
   input  logic [REG_NUM-1:0]      sw_field1_wrdy_i,
   input  logic [2*REG_NUM-1:0]    field2_wdat_i,
   input  logic [3*REG_NUM-1:0]    field3_wdat_i,
   input  logic [4*REG_NUM-1:0]    field4_wdat_i,
   input  logic [REG_NUM-1:0]      field2_wvld_i,
   input  logic [REG_NUM-1:0]      field3_wvld_i,
   input  logic [REG_NUM-1:0]      field4_wvld_i,
   output logic [2*REG_NUM-1:0]    field2_rdat_o,
   output logic [3*REG_NUM-1:0]    field3_rdat_o,
   output logic [4*REG_NUM-1:0]    field4_rdat_o
);

   localparam int STRIDE_LOG2 = $clog2(REG_STRIDE);

   dec_t              wr_dec, rd_dec;
   logic [DATA_W-1:0] rword [REG_NUM];
   logic [DATA_W-1:0] rd_word;
   logic              wr_acc, rd_acc;

   logic              rack_vld_q, rack_vld_d;
   logic [DATA_W-1:0] rack_data_q, rack_data_d;
   logic              rack_err_q, rack_err_d;
   logic              wreq_err_q, wreq_err_d;

   assign wr_dec = decode(32'(wreq_addr_i), STRIDE_LOG2, REG_NUM);
   assign rd_dec = decode(32'(rreq_addr_i), STRIDE_LOG2, REG_NUM);

   // Handshake: a transfer occurs on vld && rdy; rdy never depends on vld on either channel.
   always_comb begin
      wreq_rdy_o       = 1'b1;
      sw_field1_wvld_o = '0;
      sw_field1_wdat_o = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (wr_dec.hit && wr_dec.idx == 6'(i)) begin
            wreq_rdy_o          = sw_field1_wrdy_i[i];
            sw_field1_wvld_o[i] = wreq_vld_i && sw_field1_wrdy_i[i];
            sw_field1_wdat_o[i] = wreq_data_i[F1_LSB];
         end
      end
   end

   assign wr_acc     = wreq_vld_i && wreq_rdy_o;
   assign rreq_rdy_o = !rack_vld_q || rack_rdy_i;
   assign rd_acc     = rreq_vld_i && rreq_rdy_o;

   for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
      reg_space_rw_entry #(.DATA_W(DATA_W)) u_entry (
         .clk        (clk),
         .rst        (rst),
         .sw_we_i    (sw_field1_wvld_o[g]),
         .sw_wdata_i (wreq_data_i),
         .f2_wvld_i  (field2_wvld_i[g]),
         .f2_wdat_i  (field2_wdat_i[g*F2_W +: F2_W]),
         .f3_wvld_i  (field3_wvld_i[g]),
         .f3_wdat_i  (field3_wdat_i[g*F3_W +: F3_W]),
         .f4_wvld_i  (field4_wvld_i[g]),
         .f4_wdat_i  (field4_wdat_i[g*F4_W +: F4_W]),
         .f2_rdat_o  (field2_rdat_o[g*F2_W +: F2_W]),
         .f3_rdat_o  (field3_rdat_o[g*F3_W +: F3_W]),
         .f4_rdat_o  (field4_rdat_o[g*F4_W +: F4_W]),
         .rword_o    (rword[g])
      );
   end

   // The sampled word is the pre-edge value, so a same-cycle write is not visible.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (rd_dec.hit && rd_dec.idx == 6'(i)) rd_word = rword[i];
      end
   end

   always_comb begin
      rack_vld_d  = rack_vld_q;
      rack_data_d = rack_data_q;
      rack_err_d  = rack_err_q;
      if (rd_acc) begin
         rack_vld_d  = 1'b1;
         rack_data_d = rd_word;
         rack_err_d  = !rd_dec.hit;
      end else if (rack_rdy_i) begin
         rack_vld_d  = 1'b0;
      end
      wreq_err_d = wr_acc && !wr_dec.hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rack_vld_q  <= 1'b0;
         rack_data_q <= '0;
         rack_err_q  <= 1'b0;
         wreq_err_q  <= 1'b0;
      end else begin
         rack_vld_q  <= rack_vld_d;
         rack_data_q <= rack_data_d;
         rack_err_q  <= rack_err_d;
         wreq_err_q  <= wreq_err_d;
      end
   end

   assign rack_vld_o  = rack_vld_q;
   assign rack_data_o = rack_data_q;
   assign rack_err_o  = rack_err_q;
   assign wreq_err_o  = wreq_err_q;

endmodule

// File: tb/tb_reg_space_rw_array.sv
// Bench for reg_space_rw_array with 4 registers at stride 32: directed steps then random traffic.
module tb_reg_space_rw_array;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   rreq_addr;
   logic          rreq_vld;
   logic          rreq_rdy;
   logic [31:0]   rack_data;
   logic          rack_err;
   logic          rack_vld;
   logic          rack_rdy;
   logic [15:0]   wreq_addr;
   logic [31:0]   wreq_data;
   logic          wreq_vld;
   logic          wreq_rdy;
   logic          wreq_err;
   logic [N-1:0]  sw_field1_wdat;
   logic [N-1:0]  sw_field1_wvld;
   logic [N-1:0]  sw_field1_wrdy;
   logic [2*N-1:0] field2_wdat;
   logic [3*N-1:0] field3_wdat;
   logic [4*N-1:0] field4_wdat;
   logic [N-1:0]  field2_wvld, field3_wvld, field4_wvld;
   logic [2*N-1:0] field2_rdat;
   logic [3*N-1:0] field3_rdat;
   logic [4*N-1:0] field4_rdat;

   int checks = 0;
   int errors = 0;

   // Reference model: register contents as plain integers plus the response slot.
   int          m_f2 [N];
   int          m_f3 [N];
   int          m_f4 [N];
   bit          m_rvld;
   logic [31:0] m_rdata;
   bit          m_rerr;
   bit          m_werr;

   always #5 clk = ~clk;

   reg_space_rw_array #(.ADDR_W(16), .DATA_W(32), .REG_NUM(N), .REG_STRIDE(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .rreq_addr_i      (rreq_addr),
      .rreq_vld_i       (rreq_vld),
      .rreq_rdy_o       (rreq_rdy),
      .rack_data_o      (rack_data),
      .rack_err_o       (rack_err),
      .rack_vld_o       (rack_vld),
      .rack_rdy_i       (rack_rdy),
      .wreq_addr_i      (wreq_addr),
      .wreq_data_i      (wreq_data),
      .wreq_vld_i       (wreq_vld),
      .wreq_rdy_o       (wreq_rdy),
      .wreq_err_o       (wreq_err),
      .sw_field1_wdat_o (sw_field1_wdat),
      .sw_field1_wvld_o (sw_field1_wvld),
      .sw_field1_wrdy_i (sw_field1_wrdy),
      .field2_wdat_i    (field2_wdat),
      .field3_wdat_i    (field3_wdat),
      .field4_wdat_i    (field4_wdat),
      .field2_wvld_i    (field2_wvld),
      .field3_wvld_i    (field3_wvld),
      .field4_wvld_i    (field4_wvld),
      .field2_rdat_o    (field2_rdat),
      .field3_rdat_o    (field3_rdat),
      .field4_rdat_o    (field4_rdat)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_word(input int i);
      return 32'((m_f2[i] << 2) | (m_f3[i] << 4) | (m_f4[i] << 8));
   endfunction

   // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
   task automatic tick();
      bit         whit, rhit, e_wrdy, e_rrdy, wacc, racc, was_rst;
      int         widx, ridx;
      logic [N-1:0] e_wvld;
      #1;
      whit   = (wreq_addr % 32 == 0) && (wreq_addr / 32 < N);
      widx   = wreq_addr / 32;
      rhit   = (rreq_addr % 32 == 0) && (rreq_addr / 32 < N);
      ridx   = rreq_addr / 32;
      e_wrdy = whit ? sw_field1_wrdy[widx] : 1'b1;
      e_rrdy = !m_rvld || rack_rdy;
      e_wvld = '0;
      if (wreq_vld && e_wrdy && whit) e_wvld[widx] = 1'b1;
      chk("wreq_rdy", 64'(wreq_rdy), 64'(e_wrdy));
      chk("f1_wvld", 64'(sw_field1_wvld), 64'(e_wvld));
      chk("f1_wdat", 64'(sw_field1_wdat & e_wvld), 64'(wreq_data[0] ? e_wvld : '0));
      chk("rreq_rdy", 64'(rreq_rdy), 64'(e_rrdy));
      wacc    = wreq_vld && e_wrdy;
      racc    = rreq_vld && e_rrdy;
      was_rst = rst;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_f2[i] = 0; m_f3[i] = 0; m_f4[i] = 0;
         end
         m_rvld = 0; m_rdata = '0; m_rerr = 0; m_werr = 0;
      end else begin
         if (racc) begin
            m_rvld  = 1;
            m_rdata = rhit ? m_word(ridx) : 32'h0;
            m_rerr  = !rhit;
         end else if (rack_rdy) begin
            m_rvld = 0;
         end
         m_werr = wacc && !whit;
         for (int i = 0; i < N; i++) begin
            bit sw = wacc && whit && (widx == i);
            if (field2_wvld[i]) m_f2[i] = int'(field2_wdat[i*2 +: 2]);
            else if (sw)        m_f2[i] = int'(wreq_data[3:2]);
            if (field3_wvld[i]) m_f3[i] = int'(field3_wdat[i*3 +: 3]);
            else if (sw)        m_f3[i] = int'(wreq_data[6:4]);
            if (field4_wvld[i]) m_f4[i] = int'(field4_wdat[i*4 +: 4]);
            else if (sw)        m_f4[i] = int'(wreq_data[11:8]);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("field2", 64'(field2_rdat[i*2 +: 2]), 64'(m_f2[i]));
         chk("field3", 64'(field3_rdat[i*3 +: 3]), 64'(m_f3[i]));
         chk("field4", 64'(field4_rdat[i*4 +: 4]), 64'(m_f4[i]));
      end
      chk("rack_vld", 64'(rack_vld), 64'(m_rvld));
      chk("wreq_err", 64'(wreq_err), 64'(m_werr));
      if (m_rvld || was_rst) begin
         chk("rack_data", 64'(rack_data), 64'(m_rdata));
         chk("rack_err", 64'(rack_err), 64'(m_rerr));
      end
   endtask

   task automatic idle();
      rreq_vld    = 1'b0;
      wreq_vld    = 1'b0;
      field2_wvld = '0;
      field3_wvld = '0;
      field4_wvld = '0;
   endtask

   initial begin
      rst = 1'b1; rreq_addr = '0; rreq_vld = 1'b0; rack_rdy = 1'b1;
      wreq_addr = '0; wreq_data = '0; wreq_vld = 1'b0; sw_field1_wrdy = '1;
      field2_wdat = '0; field3_wdat = '0; field4_wdat = '0;
      field2_wvld = '0; field3_wvld = '0; field4_wvld = '0;
      for (int i = 0; i < N; i++) begin
         m_f2[i] = 0; m_f3[i] = 0; m_f4[i] = 0;
      end
      m_rvld = 0; m_rdata = '0; m_rerr = 0; m_werr = 0;

      tick(); tick();
      chk("reset_rack_vld", 64'(rack_vld), 64'd0);
      chk("reset_fields", 64'({field2_rdat, field3_rdat, field4_rdat}), 64'd0);
      rst = 1'b0;

      // Full-word write to register 0 then read it back.
      wreq_vld = 1'b1; wreq_addr = 16'h0; wreq_data = 32'h0000_0F7D;
      tick();
      chk("tp1_f2", 64'(field2_rdat[1:0]), 64'd3);
      chk("tp1_f3", 64'(field3_rdat[2:0]), 64'd7);
      chk("tp1_f4", 64'(field4_rdat[3:0]), 64'hF);
      idle(); rreq_vld = 1'b1; rreq_addr = 16'h0;
      tick();
      chk("tp1_read", 64'(rack_data), 64'h0000_0F7C);
      chk("tp1_read_err", 64'(rack_err), 64'd0);
      idle(); tick();

      // Register 3 only; register 2 stays zero.
      wreq_vld = 1'b1; wreq_addr = 16'h60; wreq_data = 32'h0000_0A00;
      tick();
      chk("tp2_f4_r3", 64'(field4_rdat[15:12]), 64'hA);
      idle(); rreq_vld = 1'b1; rreq_addr = 16'h40;
      tick();
      chk("tp2_read_r2", 64'(rack_data), 64'd0);
      idle(); tick();

      // HW write to field3 beats SW; field2 still takes SW data.
      field3_wvld = 4'b0001; field3_wdat = 12'h002;
      wreq_vld = 1'b1; wreq_addr = 16'h0; wreq_data = 32'h0000_0074;
      tick();
      chk("tp3_f3_hw", 64'(field3_rdat[2:0]), 64'd2);
      chk("tp3_f2_sw", 64'(field2_rdat[1:0]), 64'd1);
      idle();

      // Unmapped read (misaligned) and unmapped write (beyond array).
      rreq_vld = 1'b1; rreq_addr = 16'h24;
      tick();
      chk("tp4_rerr", 64'(rack_err), 64'd1);
      chk("tp4_rdata", 64'(rack_data), 64'd0);
      idle(); wreq_vld = 1'b1; wreq_addr = 16'h80; wreq_data = 32'hFFFF_FFFF;
      tick();
      chk("tp4_werr", 64'(wreq_err), 64'd1);
      idle(); tick();
      chk("tp4_werr_pulse", 64'(wreq_err), 64'd0);

      // Consumer back-pressure on register 1, then exactly-once acceptance.
      sw_field1_wrdy = 4'b1101;
      wreq_vld = 1'b1; wreq_addr = 16'h20; wreq_data = 32'h0000_0301;
      for (int k = 0; k < 3; k++) tick();
      chk("tp5_stalled_f4", 64'(field4_rdat[7:4]), 64'd0);
      sw_field1_wrdy = 4'b1111;
      tick();
      chk("tp5_f4_r1", 64'(field4_rdat[7:4]), 64'd3);
      idle(); tick();

      // Response stall then reset mid-stall.
      rack_rdy = 1'b0; rreq_vld = 1'b1; rreq_addr = 16'h0;
      tick();
      idle();
      for (int k = 0; k < 3; k++) tick();
      chk("tp6_hold_data", 64'(rack_data), 64'(m_word(0)));
      rst = 1'b1;
      tick();
      rst = 1'b0; rack_rdy = 1'b1;
      chk("tp6_rst_vld", 64'(rack_vld), 64'd0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] addrs [8];
         addrs = '{16'h0, 16'h20, 16'h40, 16'h60, 16'h80, 16'h24, 16'h61, 16'h0};
         addrs[7] = 16'($urandom_range(0, 16'hFFFF));
         rst            = ($urandom_range(0, 99) == 0);
         rreq_vld       = $urandom_range(0, 1) == 1;
         rreq_addr      = addrs[$urandom_range(0, 7)];
         rack_rdy       = $urandom_range(0, 3) != 0;
         wreq_vld       = $urandom_range(0, 1) == 1;
         wreq_addr      = addrs[$urandom_range(0, 7)];
         wreq_data      = $urandom;
         sw_field1_wrdy = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         field2_wdat    = 8'($urandom);
         field3_wdat    = 12'($urandom);
         field4_wdat    = 16'($urandom);
         field2_wvld    = 4'($urandom) & 4'($urandom);
         field3_wvld    = 4'($urandom) & 4'($urandom);
         field4_wvld    = 4'($urandom) & 4'($urandom);
         tick();
      end
      rst = 1'b0; idle(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_space_rw_array.md
# reg_space_rw_array

Parametrised register space: REG_NUM identical registers at a fixed address stride, each holding one software write-pulse field and three HW/SW shared fields. Unlike the write-only register space it replaces, it has a full read path with a one-entry response buffer and `rack` back-pressure. It also flags errors on unmapped accesses and applies write back-pressure from the pulse-field consumer. It sits between the bus-to-register bridge and the block's control/status logic.

## Interface
Parameters:
- ADDR_W, 16, request address width
- DATA_W, 32, data width; must be ≥ 12
- REG_NUM, 2, number of registers; 1..64
- REG_STRIDE, 32, byte distance between registers; power of two

Ports (N = REG_NUM):
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk
- rreq_addr  in  ADDR_W  read address
- rreq_vld / rreq_rdy  in / out  1  read request handshake
- rack_data  out  DATA_W  read data
- rack_err  out  1  read targeted an unmapped address
- rack_vld / rack_rdy  out / in  1  read response handshake
- wreq_addr  in  ADDR_W  write address
- wreq_data  in  DATA_W  write data
- wreq_vld / wreq_rdy  in / out  1  write request handshake
- wreq_err  out  1  one-cycle pulse: the previous accepted write was unmapped
- sw_field1_wdat / sw_field1_wvld  out  N  per-register write pulse: bit 0 of the write data, plus its valid
- sw_field1_wrdy  in  N  per-register consumer ready
- field2_wdat / field3_wdat / field4_wdat  in  2N / 3N / 4N  hardware write data; register i occupies slice [i*w +: w]
- field2_wvld / field3_wvld / field4_wvld  in  N  hardware write enables
- field2_rdat / field3_rdat / field4_rdat  out  2N / 3N / 4N  current field values

## Operation
- Address decode:
  - Mapped when `addr % REG_STRIDE == 0` and `addr / REG_STRIDE < REG_NUM`.
  - idx = addr / REG_STRIDE.
- Register layout:
  - field1 at bit 0: write-only pulse, always reads 0.
  - field2 at [3:2], field3 at [6:4], field4 at [11:8].
  - All other bits read 0.
- Write, mapped address:
  - wreq_rdy = sw_field1_wrdy[idx].
  - On wreq_vld && wreq_rdy: sw_field1_wvld[idx] = 1 and sw_field1_wdat[idx] = wreq_data[0], both combinational in the same cycle.
  - On that same accepted write, fields 2–4 of register idx load their data bits at the next edge.
- Write, unmapped address: wreq_rdy = 1, the data is dropped, and wreq_err pulses for one cycle after acceptance.
- sw_field1_wvld is combinational from wreq_vld/addr, as a pulse; it is not registered. sw_field1_wvld[j] = 0 for every j ≠ idx.
- A field's hardware wvld beats a same-cycle software write to that field. Other fields of the register still take the software value.
- Read:
  - rreq_rdy = !rack_vld || rack_rdy, i.e. a single response slot with full throughput.
  - On acceptance, the register is sampled into rack_data and rack_err is set for unmapped addresses (rack_data = 0 in that case).
  - rack_vld is set at the next edge.
  - rack_data and rack_err hold stable while rack_vld && !rack_rdy.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- field*_rdat are direct register outputs; there is no valid signal because the value is always valid.

## Timing
- Reset (rst high at an edge): all fields are 0, and rack_vld, rack_data, rack_err and wreq_err are 0.
- Reset mid-transaction: any pending response is discarded. A master must not rely on a rack after rst.
- Read latency is 1 cycle from acceptance to rack_vld. Back-to-back reads with rack_rdy = 1 sustain 1 per cycle.
- Write latency is 1 cycle to field2–4_rdat. The field1 pulse appears in cycle 0 (same cycle as acceptance).
- Read and write channels are independent and may both fire in the same cycle.
- wreq_rdy and rreq_rdy have no combinational path from wreq_vld or rreq_vld.

## Structure
- Package reg_space_pkg holds:
  - field LSB/width constants (F1_LSB=0, F2_LSB=2/W=2, F3_LSB=4/W=3, F4_LSB=8/W=4);
  - a decode function returning {hit, idx}.
- Sub-module reg_space_rw_entry:
  - one register: three fields with HW-priority update, plus packed read-back of the register word.
  - instantiated REG_NUM times in a generate loop.
- The top level holds decode, the read response buffer, wreq_err and the output muxing.

## Test plan
- Reset, then write 0x0000_0F7D to addr 0 → field1 pulse carries 1; field2=3, field3=7, field4=0xF. A read of addr 0 then returns 0x0000_0F7C with rack_err=0.
- REG_NUM=4, REG_STRIDE=32: write 0xA00 to addr 0x60 → only register 3 updates (field4=0xA). Read addr 0x40 → 0.
- Same cycle: field3_wvld[0]=1 with wdat=2, and SW write to addr 0 with data 0x0000_0074 → field3=2, field2=1.
- Read addr 0x24 (misaligned) → rack_data=0, rack_err=1. Write to addr 0x80 (beyond the registers) → wreq_rdy=1, wreq_err pulses, no field changes.
- sw_field1_wrdy[1]=0 with a write to addr 0x20 → wreq_rdy=0 and the write stalls. Raise wrdy → accepted exactly once.
- Hold rack_rdy=0 for 3 cycles after a read → rack_data stable and rreq_rdy=0. Assert rst mid-stall → rack_vld=0 on the next cycle.
